weyl_stream_sched: RTL

- Round-robin scheduler that shares one Weyl-permuted thermometer table between N requesters and serialises the selected pattern into a 1-bit stochastic bitstream.
- Each granted request produces exactly BITSTREAM bits, emitted LSB-index first, with a valid/ready output handshake.
- Sits between operand producers (quota sources) and stochastic-computing arithmetic lanes.

---
 rtl/weyl_stream_sched.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/weyl_stream_sched.sv
// rtl/weyl_stream_sched.sv - round-robin Weyl thermometer bitstream scheduler (option: WEYL_SCHED_ONES_CHECK_EN)
module weyl_stream_sched #(
   parameter  int N_REQ     = 4,
   parameter  int BITSTREAM = 64,
   parameter  int BASE      = 61,
   parameter  int STRIDE    = 17,
   localparam int QW        = $clog2(BITSTREAM),
   localparam int IDW       = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [N_REQ*QW-1:0]   req_quota,
   output logic [N_REQ-1:0]      req_grant,
   output logic                  bs_valid,
   input  logic                  bs_ready,
   output logic                  bs_bit,
   output logic [QW-1:0]         bs_idx,
   output logic                  bs_last,
   output logic [IDW-1:0]        bs_id,
   output logic                  busy
`ifdef WEYL_SCHED_ONES_CHECK_EN
  ,output logic [QW:0]           ones_cnt,
   output logic                  cnt_err
`endif
);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_STREAM = 1'b1;

   logic [0:0]           r_state;
   logic [IDW-1:0]       r_rr_ptr;
   logic [IDW-1:0]       r_id;
   logic [QW-1:0]        r_k;
   logic [QW-1:0]        r_quota;

   logic                 w_any;
   logic [IDW-1:0]       w_win;
   logic [IDW-1:0]       w_rr_next;
   logic                 w_grant_en;
   logic                 w_stream;
   logic                 w_accept;
   logic                 w_last;
   logic                 w_bit;
   logic [BITSTREAM-1:0] w_weyl;

   // Round-robin search: scan offsets high to low so the lowest offset from r_rr_ptr wins.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      for (int off = N_REQ - 1; off >= 0; off--) begin
         if (req_valid[(int'(r_rr_ptr) + off) % N_REQ]) begin
            w_any = 1'b1;
            w_win = IDW'((int'(r_rr_ptr) + off) % N_REQ);
         end
      end
   end

   // Scatter the thermometer of r_quota through the Weyl permutation (power-of-two truncation is the modulo).
   always_comb begin
      w_weyl = '0;
      for (int i = 0; i < BITSTREAM; i++) begin
         w_weyl[QW'(BASE + i * STRIDE)] = (i < int'(r_quota));
      end
   end

   assign w_rr_next  = (w_win == IDW'(N_REQ - 1)) ? '0 : w_win + IDW'(1);
   assign w_stream   = (r_state == S_STREAM);
   assign w_grant_en = (r_state == S_IDLE) && w_any;
   assign w_last     = w_stream && (r_k == QW'(BITSTREAM - 1));
   assign w_accept   = w_stream && bs_ready;
   assign w_bit      = w_stream && w_weyl[r_k];

   assign req_grant  = w_grant_en ? (N_REQ'(1) << w_win) : '0;
   assign bs_valid   = w_stream;
   assign bs_bit     = w_bit;
   assign bs_idx     = w_stream ? r_k : '0;
   assign bs_last    = w_last;
   assign bs_id      = w_stream ? r_id : '0;
   assign busy       = w_stream;

   // Control FSM: latch the winner on grant, then advance k on every accepted beat until the last one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_rr_ptr <= '0;
         r_id     <= '0;
         r_k      <= '0;
         r_quota  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_quota  <= req_quota[w_win * QW +: QW];
                  r_id     <= w_win;
                  r_rr_ptr <= w_rr_next;
                  r_k      <= '0;
                  r_state  <= S_STREAM;
               end
            end
            default: begin
               if (bs_ready) begin
                  if (w_last) begin
                     r_k     <= '0;
                     r_state <= S_IDLE;
                  end else begin
                     r_k     <= r_k + QW'(1);
                  end
               end
            end
         endcase
      end
   end

`ifdef WEYL_SCHED_ONES_CHECK_EN
   logic [QW:0] r_ones;
   logic        r_err;

   // Count accepted ones per stream and flag a final total that disagrees with the latched quota.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ones <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_grant_en) begin
            r_ones <= '0;
         end else if (w_accept && w_bit) begin
            r_ones <= r_ones + (QW + 1)'(1);
         end
         if (w_accept && w_last && ((r_ones + (QW + 1)'(w_bit)) != {1'b0, r_quota})) begin
            r_err <= 1'b1;
         end
      end
   end

   assign ones_cnt = r_ones;
   assign cnt_err  = r_err;
`endif

endmodule
